// File: rtl/afe_sequence_engine_if.sv
// ---------------------------------------------------------------------------
// afe_sequence_engine_if
//   Bundles the sequencer's control, ROM and serial-shifter signals.
//
//   Signals:
//     enable            level, high runs the sequence, low aborts to IDLE
//     serial_ready      serial shifter idle and able to accept a transaction
//     rom_data          ROM word {opcode, payload}, one cycle after address
//     rom_address       current ROM address
//     afe_command       payload of the last SEND
//     start_transaction one-cycle pulse to the serial shifter
//     busy/done/error   sequencer status
//     send_count        SENDs issued since the last start (saturating)
//     fsm_state         debug view of the sequencer state register
//
//   Modports:
//     master  the sequencer (drives rom_address, afe_command, status)
//     slave   the surrounding logic (drives enable, serial_ready, rom_data)
//
//   Handshake: start_transaction is only ever raised from a state that was
//   entered after serial_ready was sampled high, so one pulse corresponds to
//   exactly one accepted transaction; serial_ready is ignored everywhere
//   except while waiting for the next fetch.
// ---------------------------------------------------------------------------
interface afe_sequence_engine_if #(
   parameter int ADDR_W    = 8,
   parameter int PAYLOAD_W = 20,
   parameter int OP_W      = 4,
   parameter int CNT_W     = 16
);
   logic                      enable;
   logic                      serial_ready;
   logic [OP_W+PAYLOAD_W-1:0] rom_data;
   logic [ADDR_W-1:0]         rom_address;
   logic [PAYLOAD_W-1:0]      afe_command;
   logic                      start_transaction;
   logic                      busy;
   logic                      done;
   logic                      error;
   logic [CNT_W-1:0]          send_count;
   logic [3:0]                fsm_state;

   modport master (
      input  enable, serial_ready, rom_data,
      output rom_address, afe_command, start_transaction,
             busy, done, error, send_count, fsm_state
   );

   modport slave (
      output enable, serial_ready, rom_data,
      input  rom_address, afe_command, start_transaction,
             busy, done, error, send_count, fsm_state
   );
endinterface

// File: rtl/afe_sequence_engine.sv
// ---------------------------------------------------------------------------
// afe_sequence_engine
//   ROM-driven command sequencer for the AFE serial configuration path.
//   Walks a synchronous command ROM and issues SEND words to the serial
//   shifter one at a time, paced by serial_ready. Supports END, SEND,
//   DELAY and JUMP opcodes, an illegal-opcode / address-overrun error exit
//   and a saturating SEND counter.
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high
//     bus    afe_sequence_engine_if.master (see interface file)
//
//   Optional feature macro: AFE_SEQ_DELAY_EN
//     defined   DELAY opcode, countdown register and DELAY state present
//     undefined opcode 0x2 decodes as illegal and ends in ERROR
//
//   fsm_state encoding (declaration order): IDLE=0 WAIT=1 FETCH=2 DECODE=3
//   TRIGGER=4 GAP=5 DELAY=6 DONE=7 ERROR=8.
// ---------------------------------------------------------------------------
module afe_sequence_engine #(
   parameter int ADDR_W     = 8,
   parameter int PAYLOAD_W  = 20,
   parameter int OP_W       = 4,
   parameter int DELAY_W    = 16,
   parameter int GAP_CYCLES = 1,
   parameter int CNT_W      = 16
) (
   input logic                  clk,
   input logic                  reset,
   afe_sequence_engine_if.master bus
);

   if (PAYLOAD_W < ADDR_W || PAYLOAD_W < DELAY_W || GAP_CYCLES < 1) begin : g_param_check
      $error("afe_sequence_engine: illegal parameter combination");
   end

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT,
      S_FETCH,
      S_DECODE,
      S_TRIGGER,
      S_GAP,
      S_DELAY,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [OP_W-1:0] OP_END   = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SEND  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_DELAY = OP_W'(2);
   localparam logic [OP_W-1:0] OP_JUMP  = OP_W'(3);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t                state;
   logic [ADDR_W-1:0]     rom_address;
   logic [PAYLOAD_W-1:0]  afe_command;
   logic [CNT_W-1:0]      send_count;
   logic [GAP_W-1:0]      gap_cnt;
`ifdef AFE_SEQ_DELAY_EN
   logic [DELAY_W-1:0]    delay_cnt;
`endif

   logic [OP_W-1:0]       opcode;
   logic [PAYLOAD_W-1:0]  payload;

   assign opcode  = bus.rom_data[OP_W+PAYLOAD_W-1 -: OP_W];
   assign payload = bus.rom_data[PAYLOAD_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         rom_address <= '0;
         afe_command <= '0;
         send_count  <= '0;
         gap_cnt     <= '0;
`ifdef AFE_SEQ_DELAY_EN
         delay_cnt   <= '0;
`endif
      end else if (!bus.enable) begin
         // Abort wins over every other transition; afe_command is kept so
         // the shifter's last word stays visible.
         state       <= S_IDLE;
         rom_address <= '0;
         send_count  <= '0;
      end else begin
         unique case (state)
            S_IDLE:  state <= S_WAIT;
            S_WAIT:  if (bus.serial_ready) state <= S_FETCH;
            S_FETCH: state <= S_DECODE;  // ROM read latency
            S_DECODE: begin
               unique case (opcode)
                  OP_END:  state <= S_DONE;
                  OP_SEND: begin
                     afe_command <= payload;
                     state       <= S_TRIGGER;
                  end
`ifdef AFE_SEQ_DELAY_EN
                  OP_DELAY: begin
                     delay_cnt <= payload[DELAY_W-1:0];
                     state     <= S_DELAY;
                  end
`endif
                  OP_JUMP: begin
                     rom_address <= payload[ADDR_W-1:0];
                     state       <= S_WAIT;
                  end
                  default: state <= S_ERROR;
               endcase
            end
            S_TRIGGER: begin
               if (send_count != CNT_MAX) send_count <= send_count + CNT_W'(1);
               gap_cnt <= GAP_LAST;
               state   <= S_GAP;
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  // The address never wraps: stepping past the last word is
                  // an overrun and the address stays on the last word.
                  if (rom_address == ADDR_LAST) begin
                     state <= S_ERROR;
                  end else begin
                     rom_address <= rom_address + ADDR_W'(1);
                     state       <= S_WAIT;
                  end
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            S_DELAY: begin
`ifdef AFE_SEQ_DELAY_EN
               // A count of N spends N+1 cycles here.
               if (delay_cnt == '0) begin
                  if (rom_address == ADDR_LAST) begin
                     state <= S_ERROR;
                  end else begin
                     rom_address <= rom_address + ADDR_W'(1);
                     state       <= S_WAIT;
                  end
               end else begin
                  delay_cnt <= delay_cnt - DELAY_W'(1);
               end
`else
               state <= S_ERROR;  // unreachable without the delay feature
`endif
            end
            S_DONE:  state <= S_DONE;
            S_ERROR: state <= S_ERROR;
            default: state <= S_ERROR;
         endcase
      end
   end

   // Status outputs are decoded straight from the state register.
   assign bus.rom_address       = rom_address;
   assign bus.afe_command       = afe_command;
   assign bus.send_count        = send_count;
   assign bus.start_transaction = (state == S_TRIGGER);
   assign bus.done              = (state == S_DONE);
   assign bus.error             = (state == S_ERROR);
   assign bus.busy              = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign bus.fsm_state         = state;

endmodule
